// File: rtl/kgp_rf_pkg.sv
// kgp_rf_pkg: shared constants and types for the KGP_RISC register file.
package kgp_rf_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    // r0 is hard-wired to zero; r31 is the branch-and-link target.
    localparam int ZERO_REG = 0;
    localparam int LINK_REG = 31;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/kgp_rf_read_port.sv
// kgp_rf_read_port: one combinational read port of the register file.
// Handles address decode, r0 forcing and, when KGP_RF_BYPASS_EN is
// defined, forwarding of same-cycle write data (link has priority).
module kgp_rf_read_port
    import kgp_rf_pkg::*;
#(
    parameter int DATA_W   = kgp_rf_pkg::DATA_W,
    parameter int NUM_REGS = kgp_rf_pkg::NUM_REGS,
    parameter int ADDR_W   = kgp_rf_pkg::ADDR_W
) (
    input  logic                               rst_n,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]    mem,
    input  logic [ADDR_W-1:0]                  addr,
    input  logic                               wr_en,
    input  logic [ADDR_W-1:0]                  wr_addr,
    input  logic [DATA_W-1:0]                  wr_data,
    input  logic                               link_en,
    input  logic [DATA_W-1:0]                  link_data,
    output logic [DATA_W-1:0]                  rdata
);

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

`ifndef KGP_RF_BYPASS_EN
    // Write-side inputs only matter for forwarding; keep them tied off here.
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_addr, wr_data, link_en, link_data};
`endif

    // Select stored (or forwarded) data; r0 and reset always read zero.
    always_comb begin
        rdata = '0;
        if (rst_n && addr != ZERO_A) begin
            rdata = mem[addr];
`ifdef KGP_RF_BYPASS_EN
            if (link_en && addr == LINK_A)
                rdata = link_data;
            else if (wr_en && addr == wr_addr)
                rdata = wr_data;
`endif
        end
    end

endmodule

// File: rtl/kgp_regfile.sv
// kgp_regfile: KGP_RISC architectural register file. Two combinational
// read ports, a writeback port and a dedicated r31 link port. Link beats
// writeback on an r31 collision and raises wr_conflict for one cycle.
// Optional same-cycle forwarding: define KGP_RF_BYPASS_EN.
module kgp_regfile
    import kgp_rf_pkg::*;
#(
    parameter int DATA_W   = kgp_rf_pkg::DATA_W,
    parameter int NUM_REGS = kgp_rf_pkg::NUM_REGS,
    parameter int ADDR_W   = kgp_rf_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              link_en,
    input  logic [DATA_W-1:0] link_data,
    output logic              wr_conflict
);

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

    logic [NUM_REGS-1:0][DATA_W-1:0] mem;
    logic                            wb_to_link;
    logic                            wb_commit;

    // Writeback targets r31 while a link write is in flight: link wins.
    assign wb_to_link = wr_en && link_en && (wr_addr == LINK_A);
    assign wb_commit  = wr_en && (wr_addr != ZERO_A) && !wb_to_link;

    // Storage update and one-shot collision flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem         <= '0;
            wr_conflict <= 1'b0;
        end else begin
            wr_conflict <= wb_to_link;
            if (wb_commit)
                mem[wr_addr] <= wr_data;
            if (link_en)
                mem[LINK_A] <= link_data;
        end
    end

    kgp_rf_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_rd_a (
        .rst_n     (rst_n),
        .mem       (mem),
        .addr      (ra_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .link_en   (link_en),
        .link_data (link_data),
        .rdata     (ra_data)
    );

    kgp_rf_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_rd_b (
        .rst_n     (rst_n),
        .mem       (mem),
        .addr      (rb_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .link_en   (link_en),
        .link_data (link_data),
        .rdata     (rb_data)
    );

endmodule

// File: tb/tb_kgp_regfile.sv
// tb_kgp_regfile: directed table, reset sequence and randomized run
// against an array model of the register file.
module tb_kgp_regfile;
    import kgp_rf_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ra_addr, rb_addr, wr_addr;
    logic [31:0] ra_data, rb_data, wr_data, link_data;
    logic        wr_en, link_en, wr_conflict;

    always #5 clk = ~clk;

    kgp_regfile dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ra_addr     (ra_addr),
        .ra_data     (ra_data),
        .rb_addr     (rb_addr),
        .rb_data     (rb_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .link_en     (link_en),
        .link_data   (link_data),
        .wr_conflict (wr_conflict)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Same-cycle read of a register being written.
`ifdef KGP_RF_BYPASS_EN
    localparam logic [31:0] SAME7  = 32'hF0F0F0F0;
`else
    localparam logic [31:0] SAME7  = 32'h0;
`endif

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        le;
        logic [31:0] ld;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] era;
        logic [31:0] erb;
        logic        ec;
    } vec_t;

    vec_t tbl[12];

    // Reference model: plain array of architectural registers.
    logic [31:0] m [32];
    logic        exp_conf;

    function automatic logic [31:0] ref_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef KGP_RF_BYPASS_EN
        if (link_en && a == 5'd31) return link_data;
        if (wr_en && a == wr_addr) return wr_data;
`endif
        return m[a];
    endfunction

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic le, input logic [31:0] ld,
                         input logic [4:0] ra, input logic [4:0] rb);
        wr_en = we; wr_addr = wa; wr_data = wd;
        link_en = le; link_data = ld;
        ra_addr = ra; rb_addr = rb;
    endtask

    initial begin
        drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 5'd0);
        rst_n = 1'b0;

        // Table: expected read values are the pre-edge contents; ec is
        // the flag raised by the previous row.
        tbl[0]  = '{1'b1, 5'd3,  32'h0F0F0F0F, 1'b0, 32'h0,   5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
        tbl[1]  = '{1'b1, 5'd4,  32'd56,       1'b0, 32'h0,   5'd3,  5'd0,  32'h0F0F0F0F, 32'h0,        1'b0};
        tbl[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,   5'd3,  5'd4,  32'h0F0F0F0F, 32'h00000038, 1'b0};
        tbl[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 32'h0,   5'd3,  5'd0,  32'h0F0F0F0F, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,   5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
        tbl[5]  = '{1'b1, 5'd31, 32'hDEADBEEF, 1'b1, 32'h104, 5'd4,  5'd3,  32'h00000038, 32'h0F0F0F0F, 1'b0};
        tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,   5'd31, 5'd31, 32'h104,      32'h104,      1'b1};
        tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,   5'd31, 5'd0,  32'h104,      32'h0,        1'b0};
        tbl[8]  = '{1'b1, 5'd7,  32'hF0F0F0F0, 1'b0, 32'h0,   5'd7,  5'd7,  SAME7,        SAME7,        1'b0};
        tbl[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,   5'd7,  5'd0,  32'hF0F0F0F0, 32'h0,        1'b0};
        tbl[10] = '{1'b1, 5'd14, 32'd35,       1'b1, 32'h200, 5'd7,  5'd3,  32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0};
        tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,   5'd31, 5'd14, 32'h200,      32'h00000023, 1'b0};

        #12;
        chk("reset_ra", ra_data, 32'h0);
        chk("reset_rb", rb_data, 32'h0);
        chk("reset_conflict", {31'h0, wr_conflict}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].le, tbl[i].ld, tbl[i].ra, tbl[i].rb);
            @(negedge clk);
            chk($sformatf("tbl%0d_ra", i), ra_data, tbl[i].era);
            chk($sformatf("tbl%0d_rb", i), rb_data, tbl[i].erb);
            chk($sformatf("tbl%0d_conflict", i), {31'h0, wr_conflict}, {31'h0, tbl[i].ec});
            @(posedge clk); #1;
        end

        // Asynchronous reset mid-run, writes ignored while held.
        drive(1'b1, 5'd5, 32'h12345678, 1'b0, 32'h0, 5'd5, 5'd5);
        @(posedge clk); #1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd5, 5'd5);
        #1;
        chk("pre_reset_r5", ra_data, 32'h12345678);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_ra", ra_data, 32'h0);
        chk("async_reset_rb", rb_data, 32'h0);
        drive(1'b1, 5'd5, 32'hAAAA5555, 1'b1, 32'h55AA, 5'd5, 5'd31);
        @(posedge clk); #1;
        chk("reset_hold_ra", ra_data, 32'h0);
        chk("reset_hold_rb", rb_data, 32'h0);
        chk("reset_hold_conflict", {31'h0, wr_conflict}, 32'h0);
        // Release between edges with a write pending: it lands on the next edge.
        drive(1'b1, 5'd6, 32'h66, 1'b0, 32'h0, 5'd5, 5'd6);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd5, 5'd6);
        #1;
        chk("after_reset_r5", ra_data, 32'h0);
        chk("first_write_r6", rb_data, 32'h66);

        // Clean reset, then randomized traffic against the model.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        foreach (m[k]) m[k] = 32'h0;
        exp_conf = 1'b0;
        @(posedge clk); #1;
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa;
            wa = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 2) == 0),
                  $urandom,
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31)));
            @(negedge clk);
            chk($sformatf("rnd%0d_ra", n), ra_data, ref_rd(ra_addr));
            chk($sformatf("rnd%0d_rb", n), rb_data, ref_rd(rb_addr));
            chk($sformatf("rnd%0d_conflict", n), {31'h0, wr_conflict}, {31'h0, exp_conf});
            exp_conf = wr_en && link_en && wr_addr == 5'd31;
            if (wr_en && wr_addr != 5'd0) m[wr_addr] = wr_data;
            if (link_en) m[31] = link_data;
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
